// File: rtl/oled_pkg.sv
// ----------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the OLED (SSD1306) sequencers: FSM state encodings
// for the frame writer and the byte handshake, and the panel command bytes
// used during initialisation and frame streaming.
// ----------------------------------------------------------------------------
package oled_pkg;

    // Frame writer sequencing states
    typedef enum logic [3:0] {
        StIdle,
        StCmdPage,
        StCmdColL,
        StCmdColH,
        StFetch,
        StFetchWait,
        StData,
        StWaitSpi,
        StDone
    } fw_state_e;

    // Load/done/wait-low byte handshake states
    typedef enum logic [1:0] {
        XferIdle,
        XferLoad,
        XferWaitLow
    } xfer_state_e;

    // Initialisation command bytes
    localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] CMD_SET_MUX     = 8'hA8;
    localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;

    // Frame addressing command bytes (page addressing mode)
    localparam logic [7:0] CMD_PAGE_BASE   = 8'hB0;
    localparam logic [7:0] CMD_COL_LO      = 8'h00;
    localparam logic [7:0] CMD_COL_HI      = 8'h10;

    // Page-start command: the SSD1306 page field is 3 bits wide
    function automatic logic [7:0] page_cmd(input logic [2:0] page);
        return CMD_PAGE_BASE | {5'b0, page};
    endfunction

endpackage

// File: rtl/oled_byte_xfer.sv
// ----------------------------------------------------------------------------
// oled_byte_xfer
// One-byte handshake towards spi_controller: on go, latch the byte and raise
// spi_load_data; hold it until spi_done is sampled high, then drop it and wait
// for spi_done to fall again before accepting the next byte.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   go              start a transfer (honoured only while idle)
//   tx_byte         byte to send ("byte" is a reserved word)
//   spi_done        spi_controller.data_sent
//   spi_data        registered byte to spi_controller.data_in
//   spi_load_data   registered load request
//   idle            ready to accept go
//   load_ack        spi_done sampled while loading; load drops this edge
//   xfer_done       spi_done seen low after the ack; handshake finished
// ----------------------------------------------------------------------------
module oled_byte_xfer
    import oled_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       spi_done,
    output logic [7:0] spi_data,
    output logic       spi_load_data,
    output logic       idle,
    output logic       load_ack,
    output logic       xfer_done
);

    xfer_state_e state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= XferIdle;
            spi_data      <= 8'h00;
            spi_load_data <= 1'b0;
        end else begin
            case (state_q)
                XferIdle: begin
                    if (go) begin
                        spi_data      <= tx_byte;
                        spi_load_data <= 1'b1;
                        state_q       <= XferLoad;
                    end
                end
                XferLoad: begin
                    if (spi_done) begin
                        spi_load_data <= 1'b0;
                        state_q       <= XferWaitLow;
                    end
                end
                XferWaitLow: begin
                    if (!spi_done) begin
                        state_q <= XferIdle;
                    end
                end
                default: state_q <= XferIdle;
            endcase
        end
    end

    assign idle      = (state_q == XferIdle);
    assign load_ack  = (state_q == XferLoad) && spi_done;
    assign xfer_done = (state_q == XferWaitLow) && !spi_done;

endmodule

// File: rtl/oled_frame_writer.sv
// ----------------------------------------------------------------------------
// oled_frame_writer
// After panel initialisation, pushes one full frame from a byte-wide frame
// buffer to an SSD1306 through spi_controller. For each page it sends the
// page/column address commands (DC low) and then COLS data bytes (DC high).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   init_done       panel init complete; start ignored while low
//   start           one-cycle frame request (ignored unless idle)
//   busy            high from accepted start until frame_done
//   frame_done      one-cycle pulse after the last data byte completes
//   mem_addr        registered frame-buffer read address
//   mem_rdata       frame-buffer data, valid the cycle after mem_addr
//   spi_data        byte to spi_controller.data_in
//   spi_load_data   spi_controller.load_data
//   spi_done        spi_controller.data_sent
//   oled_dc_n       0 = command, 1 = data
//   refresh_en      only with OLED_FW_REFRESH_EN: restart the next frame
//                   straight from DONE while high
//
// Build option: define OLED_FW_REFRESH_EN to add refresh_en and continuous
// back-to-back frames.
// ----------------------------------------------------------------------------
module oled_frame_writer
    import oled_pkg::*;
#(
    parameter int unsigned PAGES = 4,
    parameter int unsigned COLS  = 128,
    parameter int unsigned AW    = $clog2(PAGES * COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_done,
    input  logic          start,
`ifdef OLED_FW_REFRESH_EN
    input  logic          refresh_en,
`endif
    output logic          busy,
    output logic          frame_done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    spi_data,
    output logic          spi_load_data,
    input  logic          spi_done,
    output logic          oled_dc_n
);

    localparam int unsigned PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

    fw_state_e     state_q;
    fw_state_e     sender_q;   // send state to resume from after WAIT_SPI
    logic [PW-1:0] page_q;
    logic [CW-1:0] col_q;
    logic [7:0]    data_q;

    logic       xfer_go;
    logic [7:0] xfer_byte;
    logic       xfer_idle;
    logic       xfer_ack;
    logic       xfer_done;
    logic       refresh_req;

`ifdef OLED_FW_REFRESH_EN
    assign refresh_req = refresh_en;
`else
    assign refresh_req = 1'b0;
`endif

    // Each send state launches its byte once, on entry, while the handshake
    // is idle; afterwards it just waits for the acknowledge.
    always_comb begin
        xfer_go   = 1'b0;
        xfer_byte = 8'h00;
        case (state_q)
            StCmdPage: begin
                xfer_go   = xfer_idle;
                xfer_byte = page_cmd(3'(page_q));
            end
            StCmdColL: begin
                xfer_go   = xfer_idle;
                xfer_byte = CMD_COL_LO;
            end
            StCmdColH: begin
                xfer_go   = xfer_idle;
                xfer_byte = CMD_COL_HI;
            end
            StData: begin
                xfer_go   = xfer_idle;
                xfer_byte = data_q;
            end
            default: ;
        endcase
    end

    oled_byte_xfer u_byte_xfer (
        .clk           (clk),
        .rst           (rst),
        .go            (xfer_go),
        .tx_byte       (xfer_byte),
        .spi_done      (spi_done),
        .spi_data      (spi_data),
        .spi_load_data (spi_load_data),
        .idle          (xfer_idle),
        .load_ack      (xfer_ack),
        .xfer_done     (xfer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sender_q   <= StIdle;
            page_q     <= '0;
            col_q      <= '0;
            data_q     <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            mem_addr   <= '0;
            oled_dc_n  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && init_done) begin
                        busy      <= 1'b1;
                        page_q    <= '0;
                        col_q     <= '0;
                        oled_dc_n <= 1'b0;
                        state_q   <= StCmdPage;
                    end
                end

                StCmdPage, StCmdColL, StCmdColH, StData: begin
                    if (xfer_ack) begin
                        sender_q <= state_q;
                        state_q  <= StWaitSpi;
                    end
                end

                StFetch: begin
                    mem_addr <= AW'(32'(page_q) * COLS + 32'(col_q));
                    state_q  <= StFetchWait;
                end

                StFetchWait: begin
                    data_q  <= mem_rdata;
                    state_q <= StData;
                end

                // DC only changes here, on exit, when load and done are both low
                StWaitSpi: begin
                    if (xfer_done) begin
                        case (sender_q)
                            StCmdPage: state_q <= StCmdColL;
                            StCmdColL: state_q <= StCmdColH;
                            StCmdColH: begin
                                oled_dc_n <= 1'b1;
                                state_q   <= StFetch;
                            end
                            default: begin
                                if (col_q == COL_LAST) begin
                                    col_q <= '0;
                                    if (page_q == PAGE_LAST) begin
                                        state_q <= StDone;
                                    end else begin
                                        page_q    <= page_q + 1'b1;
                                        oled_dc_n <= 1'b0;
                                        state_q   <= StCmdPage;
                                    end
                                end else begin
                                    col_q   <= col_q + 1'b1;
                                    state_q <= StFetch;
                                end
                            end
                        endcase
                    end
                end

                StDone: begin
                    frame_done <= 1'b1;
                    oled_dc_n  <= 1'b0;
                    page_q     <= '0;
                    col_q      <= '0;
                    if (refresh_req) begin
                        state_q <= StCmdPage;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_frame_writer.sv
module tb_oled_frame_writer;

    localparam int PAGES = 4;
    localparam int COLS  = 128;
    localparam int AW    = 9;
    localparam int NXFER = PAGES * (3 + COLS);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done = 1'b0;
    logic          start = 1'b0;
`ifdef OLED_FW_REFRESH_EN
    logic          refresh_en = 1'b0;
`endif
    logic          busy;
    logic          frame_done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic [7:0]    spi_data;
    logic          spi_load_data;
    logic          spi_done = 1'b0;
    logic          oled_dc_n;

    logic [7:0] mem [0:PAGES*COLS-1];
    assign mem_rdata = mem[mem_addr];

    oled_frame_writer #(
        .PAGES (PAGES),
        .COLS  (COLS),
        .AW    (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .init_done     (init_done),
        .start         (start),
`ifdef OLED_FW_REFRESH_EN
        .refresh_en    (refresh_en),
`endif
        .busy          (busy),
        .frame_done    (frame_done),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .spi_data      (spi_data),
        .spi_load_data (spi_load_data),
        .spi_done      (spi_done),
        .oled_dc_n     (oled_dc_n)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural SPI controller: done rises rise cycles after load, falls
    // fall_delay cycles after load drops.
    int rise_delay = 20;
    int fall_delay = 3;
    bit rand_rise = 1'b0;
    int hi_cnt = 0;
    int lo_cnt = 0;
    int cur_rise = 20;

    always @(posedge clk) begin
        if (rst) begin
            spi_done <= 1'b0;
            hi_cnt = 0;
            lo_cnt = 0;
        end else if (spi_load_data) begin
            if (hi_cnt == 0) cur_rise = rand_rise ? int'($urandom_range(8, 1)) : rise_delay;
            hi_cnt++;
            lo_cnt = 0;
            if (hi_cnt >= cur_rise) spi_done <= 1'b1;
        end else begin
            hi_cnt = 0;
            if (spi_done) begin
                lo_cnt++;
                if (lo_cnt >= fall_delay) spi_done <= 1'b0;
            end
        end
    end

    // Completed transfers as {dc_n, byte}
    logic [8:0] got[$];
    logic [8:0] exp_q[$];

    always @(posedge clk) begin
        if (!rst && spi_load_data && spi_done) got.push_back({oled_dc_n, spi_data});
    end

    int cyc = 0;
    int load_rises = 0;
    int fd_count = 0;
    int fd_busy_hi = 0;
    int dc_glitch = 0;
    int load_while_done = 0;
    int busy_falls = 0;
    int last_fall_cyc = -1;
    int last_rise_cyc = -1;
    logic load_prev = 1'b0;
    logic done_prev = 1'b0;
    logic dc_prev = 1'b0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (spi_load_data && !load_prev) begin
                load_rises++;
                last_rise_cyc = cyc;
                if (spi_done) load_while_done++;
            end
            if (!spi_load_data && load_prev) last_fall_cyc = cyc;
            if (oled_dc_n !== dc_prev && (spi_load_data || spi_done || load_prev || done_prev))
                dc_glitch++;
            if (frame_done) begin
                fd_count++;
                if (busy) fd_busy_hi++;
            end
            if (!busy && busy_prev) busy_falls++;
        end
        load_prev = spi_load_data;
        done_prev = spi_done;
        dc_prev   = oled_dc_n;
        busy_prev = busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        load_rises = 0;
        fd_count = 0;
        fd_busy_hi = 0;
        dc_glitch = 0;
        load_while_done = 0;
        busy_falls = 0;
        last_fall_cyc = -1;
        last_rise_cyc = -1;
        got.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic build_exp(input int frames);
        exp_q.delete();
        for (int f = 0; f < frames; f++) begin
            for (int p = 0; p < PAGES; p++) begin
                exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
                exp_q.push_back({1'b0, 8'h00});
                exp_q.push_back({1'b0, 8'h10});
                for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, mem[p*COLS + c]});
            end
        end
    endtask

    function automatic int seq_errors();
        int e = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) e++;
        return e;
    endfunction

    task automatic wait_frames(input int target, input int budget, output bit ok);
        int n = 0;
        while (fd_count < target && n < budget) begin
            tick();
            n++;
        end
        ok = (fd_count >= target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_spi_data"}, 32'(spi_data), 0);
        check({tag, "_load"}, 32'(spi_load_data), 0);
        check({tag, "_dc_n"}, 32'(oled_dc_n), 0);
    endtask

    task automatic check_frame(input string tag, input int frames);
        build_exp(frames);
        check({tag, "_xfers"}, 32'(got.size()), 32'(frames * NXFER));
        check({tag, "_seq_errors"}, 32'(seq_errors()), 0);
        check({tag, "_load_rises"}, 32'(load_rises), 32'(frames * NXFER));
        check({tag, "_dc_glitch"}, 32'(dc_glitch), 0);
        check({tag, "_load_while_done"}, 32'(load_while_done), 0);
    endtask

    initial begin
        bit ok;
        int n;
        int gap;

        for (int a = 0; a < PAGES * COLS; a++) mem[a] = 8'(a);

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        clear_counts();

        // start without init_done is ignored
        pulse_start();
        repeat (30) tick();
        check("noinit_loads", 32'(load_rises), 0);
        check("noinit_busy", 32'(busy), 0);

        // Frame 1: buffer byte[a] = a[7:0], 20-cycle SPI; a mid-frame start is ignored
        init_done = 1'b1;
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_load_c1", 32'(spi_load_data), 0);
        tick();
        check("start_load_c2", 32'(spi_load_data), 1);
        check("start_first_cmd", 32'(spi_data), 32'h0B0);
        check("start_first_dc", 32'(oled_dc_n), 0);
        repeat (500) tick();
        pulse_start();
        wait_frames(1, 30000, ok);
        check("f1_done_timeout", 32'(ok), 1);
        check("f1_busy_at_done", 32'(busy), 0);
        repeat (60) tick();
        check("f1_done_pulses", 32'(fd_count), 1);
        check("f1_idle_after", 32'(busy), 0);
        check_frame("f1", 1);

        // Reset while the 10th data byte is in flight
        clear_counts();
        pulse_start();
        n = 0;
        while (!(got.size() >= 12 && spi_load_data) && n < 2000) begin
            tick();
            n++;
        end
        check("rst_reached_byte10", 32'(got.size()), 12);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (5) tick();
        check("midrst_idle_load", 32'(spi_load_data), 0);
        clear_counts();
        pulse_start();
        wait_frames(1, 30000, ok);
        check("f2_done_timeout", 32'(ok), 1);
        repeat (20) tick();
        check_frame("f2", 1);

        // Random frame buffer, random SPI latency
        for (int a = 0; a < PAGES * COLS; a++) mem[a] = 8'($urandom);
        rand_rise = 1'b1;
        clear_counts();
        pulse_start();
        wait_frames(1, 30000, ok);
        check("f3_done_timeout", 32'(ok), 1);
        repeat (20) tick();
        check_frame("f3", 1);
        check("f3_done_busy_low", 32'(fd_busy_hi), 0);

        // spi_done held 50 cycles after the first load drops
        rand_rise = 1'b0;
        rise_delay = 4;
        fall_delay = 50;
        clear_counts();
        pulse_start();
        n = 0;
        while (load_rises < 2 && n < 500) begin
            tick();
            n++;
        end
        gap = last_rise_cyc - last_fall_cyc;
        fall_delay = 3;
        check("stall_second_load", 32'(load_rises), 2);
        check("stall_gap_ge51", 32'(gap >= 51), 1);
        wait_frames(1, 30000, ok);
        check("f4_done_timeout", 32'(ok), 1);
        repeat (20) tick();
        check_frame("f4", 1);

`ifdef OLED_FW_REFRESH_EN
        // Continuous refresh: two frames, busy held between them
        rand_rise = 1'b1;
        clear_counts();
        refresh_en = 1'b1;
        pulse_start();
        wait_frames(1, 30000, ok);
        check("r1_done_timeout", 32'(ok), 1);
        check("r1_busy_held", 32'(busy), 1);
        repeat (100) tick();
        refresh_en = 1'b0;
        wait_frames(2, 30000, ok);
        check("r2_done_timeout", 32'(ok), 1);
        repeat (200) tick();
        check("r_done_pulses", 32'(fd_count), 2);
        check("r_busy_falls", 32'(busy_falls), 1);
        check("r_busy_hi_at_done", 32'(fd_busy_hi), 1);
        check_frame("r", 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/oled_frame_writer.md
# oled_frame_writer

Sequences the shared `spi_controller` after OLED power-up/init to push one full display frame from a byte-wide frame buffer to the SSD1306 panel. Per page it issues the page/column address commands (DC low), then streams `COLS` data bytes (DC high), using the same load/done handshake as the init sequencer. It sits beside `oled_control`, taking over the SPI byte interface and `oled_dc_n` once initialisation has finished.

## Interface
- `PAGES`, 4, number of 8-row pages per frame
- `COLS`, 128, columns (data bytes) per page
- `AW`, clog2(PAGES*COLS) = 9, frame-buffer address width
- `clk`  in  1  system clock (100 MHz)
- `rst`  in  1  reset, synchronous, active-high
- `init_done`  in  1  panel init complete; `start` is ignored while low
- `start`  in  1  one-cycle request to send one frame
- `busy`  out  1  high from accepted start until `frame_done`
- `frame_done`  out  1  one-cycle pulse after the last data byte's handshake completes
- `mem_addr`  out  AW  frame-buffer read address (registered)
- `mem_rdata`  in  8  frame-buffer data, valid 1 cycle after `mem_addr`
- `spi_data`  out  8  byte to `spi_controller.data_in`
- `spi_load_data`  out  1  to `spi_controller.load_data`
- `spi_done`  in  1  from `spi_controller.data_sent`
- `oled_dc_n`  out  1  0 = command, 1 = data
- `refresh_en`  in  1  present only with `OLED_FW_REFRESH_EN`

## Operation
- Reset values: `busy`=0, `frame_done`=0, `mem_addr`=0, `spi_data`=0, `spi_load_data`=0, `oled_dc_n`=0; state IDLE.
- States: IDLE, CMD_PAGE, CMD_COLL, CMD_COLH, FETCH, FETCH_WAIT, DATA, WAIT_SPI, DONE.
- IDLE: on `start && init_done`, set `busy`, page=0, col=0, go CMD_PAGE. `start` in any other state is ignored (not queued).
- CMD_PAGE sends 0xB0|page; CMD_COLL sends 0x00; CMD_COLH sends 0x10. `oled_dc_n`=0 for all three.
- After CMD_COLH: set `oled_dc_n`=1, go FETCH.
- FETCH: `mem_addr` <= page*COLS + col. FETCH_WAIT: `spi_data` <= `mem_rdata`. DATA: send byte.
- Byte send (every send state): drive `spi_data`, hold `spi_load_data`=1 until `spi_done`=1 is sampled; that cycle drop `spi_load_data`, go WAIT_SPI carrying return target. WAIT_SPI: leave only when `spi_done`=0.
- After a data byte: col==COLS-1 → col=0; if page==PAGES-1 go DONE, else page+1, `oled_dc_n`=0, go CMD_PAGE. Otherwise col+1, go FETCH.
- DONE: pulse `frame_done`, clear `busy`, go IDLE.
- `oled_dc_n` changes only while `spi_load_data`=0 and `spi_done`=0.
- `init_done` dropping mid-frame does not abort; the frame completes.
- Reset mid-transfer: all outputs return to reset values the next cycle; the partially sent byte is abandoned.

## Timing
- `start` to `spi_load_data` rising: 2 cycles.
- Per byte: load high until `spi_done`, then 1 cycle to drop, plus the WAIT_SPI dwell until `spi_done` falls.
- Data-byte overhead between WAIT_SPI exit and next load: 3 cycles (FETCH, FETCH_WAIT, DATA entry).
- Frame = PAGES*(3 + COLS) = 524 byte transfers at defaults.
- `frame_done` asserted 1 cycle after the final WAIT_SPI exit; `busy` low in the same cycle.

## Configuration
- `OLED_FW_REFRESH_EN` defined: `refresh_en` port exists; in DONE, if `refresh_en`=1, pulse `frame_done` and go directly to CMD_PAGE with page=0, col=0, `busy` held high; `init_done` not rechecked.
- Undefined: no `refresh_en` port; one frame per accepted `start`.

## Structure
- Shared package `oled_pkg`: state encoding, command constants `CMD_PAGE_BASE`=0xB0, `CMD_COL_LO`=0x00, `CMD_COL_HI`=0x10, alongside the existing init command constants.
- One natural sub-module: `oled_byte_xfer` — the load/done/wait-low handshake (inputs `go`, `byte`; output `xfer_done` pulse), shared with future SPI sequencers.

## Test plan
- Behavioural SPI model (`spi_done` rises 20 cycles after load, falls 3 cycles after load drops); buffer byte[a] = a[7:0]; `start` with `init_done`=1 → bytes B0,00,10, 00..7F, B1,00,10, 80..FF, …, B3,00,10, 80..FF; 524 transfers, one `frame_done`.
- `oled_dc_n` is 0 during every command byte and 1 during every data byte; it never toggles while load or done is high.
- `start` with `init_done`=0 → no load, `busy` stays 0; `start` during busy → ignored, exactly 524 transfers total.
- SPI model holds `spi_done` high 50 cycles after load drops → FSM stays in WAIT_SPI, no new load until done falls.
- `rst` asserted during the 10th data byte → next cycle all outputs at reset values; a new `start` sends a full frame from B0.
- With `OLED_FW_REFRESH_EN` and `refresh_en`=1 → two consecutive frames, `frame_done` pulses twice, `busy` never drops between them; set `refresh_en`=0 during frame 2 → stop after it.
